// File: rtl/regfile_pkg.sv
// Shared types and reset-value defaults for the multi-port register file.
package regfile_pkg;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

  localparam int RF_SP_IDX  = 2;
  localparam int RF_SP_INIT = 1020;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write bus of the multi-port register file; the core drives it as master.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                we0;
  logic [AW-1:0]       wa0;
  logic [XLEN-1:0]     wd0;
  logic                we1;
  logic [AW-1:0]       wa1;
  logic [XLEN-1:0]     wd1;
  logic                ready;
  logic                wr_collide;

  modport master (
    output rd_addr, we0, wa0, wd0, we1, wa1, wd1,
    input  rd_data, ready, wr_collide
  );

  modport slave (
    input  rd_addr, we0, wa0, wd0, we1, wa1, wd1,
    output rd_data, ready, wr_collide
  );

endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: zero register, optional write bypass, then array data.
module regfile_rdport #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            run_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] stored_i,
  input  logic            we0_i,
  input  logic [AW-1:0]   wa0_i,
  input  logic [XLEN-1:0] wd0_i,
  input  logic            we1_i,
  input  logic [AW-1:0]   wa1_i,
  input  logic [XLEN-1:0] wd1_i,
  output logic [XLEN-1:0] data_o
);

  // Port 1 is checked first so the read agrees with the value that will be stored
  always_comb begin
    data_o = stored_i;
    if (!run_i || (addr_i == {AW{1'b0}})) begin
      data_o = {XLEN{1'b0}};
    end else if ((BYPASS != 0) && we1_i && (wa1_i == addr_i)) begin
      data_o = wd1_i;
    end else if ((BYPASS != 0) && we0_i && (wa0_i == addr_i)) begin
      data_o = wd0_i;
    end else begin
      data_o = stored_i;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Dual-write, multi-read register file with a post-reset initialisation sweep
// instead of a per-register reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int SP_IDX  = RF_SP_IDX,
  parameter int SP_INIT = RF_SP_INIT
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW:0]     CNT_LAST = (AW+1)'(NREGS - 1);
  localparam logic [AW:0]     CNT_SP   = (AW+1)'(SP_IDX);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [XLEN-1:0] SP_VAL   = XLEN'(SP_INIT);

  rf_state_t           state_q, state_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                collide_q, collide_d;
  logic                run_s, eff0_s, eff1_s;
  logic [XLEN-1:0]     regs_q [NREGS];
  logic [NRD*XLEN-1:0] rd_data_s;

  assign run_s  = (state_q == RF_RUN);
  assign eff0_s = run_s && bus.we0 && (bus.wa0 != {AW{1'b0}});
  assign eff1_s = run_s && bus.we1 && (bus.wa1 != {AW{1'b0}});

  // State register, sweep counter and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RF_INIT;
      cnt_q     <= {(AW+1){1'b0}};
      ready_q   <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      collide_q <= collide_d;
    end
  end

  // Next-state logic: sweep every index once, then serve reads and writes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    collide_d = 1'b0;
    case (state_q)
      RF_INIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = RF_RUN;
          ready_d = 1'b1;
        end else begin
          ready_d = 1'b0;
        end
      end
      RF_RUN: begin
        ready_d   = 1'b1;
        collide_d = eff0_s && eff1_s && (bus.wa0 == bus.wa1);
      end
      default: begin
        state_d = RF_INIT;
        cnt_d   = {(AW+1){1'b0}};
        ready_d = 1'b0;
      end
    endcase
  end

  // Array update; port 1 is applied last so it wins an address collision
  always_ff @(posedge clk) begin
    if (!run_s) begin
      regs_q[cnt_q[AW-1:0]] <= (cnt_q == CNT_SP) ? SP_VAL : {XLEN{1'b0}};
    end else begin
      if (eff0_s) begin
        regs_q[bus.wa0] <= bus.wd0;
      end
      if (eff1_s) begin
        regs_q[bus.wa1] <= bus.wd1;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr_s;
    assign addr_s = bus.rd_addr[k*AW +: AW];

    regfile_rdport #(
      .XLEN   (XLEN),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_rdport (
      .run_i    (run_s),
      .addr_i   (addr_s),
      .stored_i (regs_q[addr_s]),
      .we0_i    (eff0_s),
      .wa0_i    (bus.wa0),
      .wd0_i    (bus.wd0),
      .we1_i    (eff1_s),
      .wa1_i    (bus.wa1),
      .wd1_i    (bus.wd1),
      .data_o   (rd_data_s[k*XLEN +: XLEN])
    );
  end

  assign bus.rd_data    = rd_data_s;
  assign bus.ready      = ready_q;
  assign bus.wr_collide = collide_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: one bypassing and one non-bypassing instance driven in lockstep.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NRD*AW-1:0]   rd_addr;
  logic                we0, we1;
  logic [AW-1:0]       wa0, wa1;
  logic [XLEN-1:0]     wd0, wd1;
  int                  n_checks = 0;
  int                  n_errors = 0;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_b ();
  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_n ();

  assign bus_b.rd_addr = rd_addr;
  assign bus_b.we0 = we0;
  assign bus_b.wa0 = wa0;
  assign bus_b.wd0 = wd0;
  assign bus_b.we1 = we1;
  assign bus_b.wa1 = wa1;
  assign bus_b.wd1 = wd1;
  assign bus_n.rd_addr = rd_addr;
  assign bus_n.we0 = we0;
  assign bus_n.wa0 = wa0;
  assign bus_n.wd0 = wd0;
  assign bus_n.we1 = we1;
  assign bus_n.wa1 = wa1;
  assign bus_n.wd1 = wd1;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = 5'd0; wd0 = 32'h0;
    we1 = 1'b0; wa1 = 5'd0; wd1 = 32'h0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs the sweep after reset release; a write attempt lands in sweep cycle 10
  task automatic run_sweep();
    for (int i = 1; i <= NREGS; i++) begin
      we0 = (i == 10); wa0 = 5'd7; wd0 = 32'hDEAD;
      tick();
      chk("sweep_ready_b", 64'(bus_b.ready), 64'(i == NREGS));
      chk("sweep_ready_n", 64'(bus_n.ready), 64'(i == NREGS));
      if (i < NREGS) begin
        chk("init_rd_zero_b", bus_b.rd_data, 64'h0);
        chk("init_rd_zero_n", bus_n.rd_data, 64'h0);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    set_rd(5'd2, 5'd5);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus_b.ready), 64'h0);
    chk("rst_collide", 64'(bus_b.wr_collide), 64'h0);
    chk("rst_rd", bus_b.rd_data, 64'h0);
    rst = 1'b0;
    run_sweep();

    chk("sweep_x2_x5_b", bus_b.rd_data, {32'd0, 32'd1020});
    chk("sweep_x2_x5_n", bus_n.rd_data, {32'd0, 32'd1020});
    chk("no_x", 64'($isunknown(bus_b.rd_data)), 64'h0);
    set_rd(5'd7, 5'd0);
    #1;
    chk("init_write_dropped_x7", bus_b.rd_data, 64'h0);

    // Collision on x5: port 1 wins
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h22;
    set_rd(5'd5, 5'd0);
    #1;
    chk("coll_bypass_b", bus_b.rd_data, {32'h0, 32'h22});
    chk("coll_nobypass_n", bus_n.rd_data, 64'h0);
    tick();
    idle();
    #1;
    chk("coll_x5_b", bus_b.rd_data, {32'h0, 32'h22});
    chk("coll_x5_n", bus_n.rd_data, {32'h0, 32'h22});
    chk("coll_pulse_b", 64'(bus_b.wr_collide), 64'h1);
    chk("coll_pulse_n", 64'(bus_n.wr_collide), 64'h1);
    tick();
    chk("coll_pulse_end", 64'(bus_b.wr_collide), 64'h0);

    // Both ports writing x0: no effect, no collision
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h33;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h44;
    set_rd(5'd0, 5'd0);
    #1;
    chk("x0_bypass_b", bus_b.rd_data, 64'h0);
    tick();
    idle();
    #1;
    chk("x0_collide", 64'(bus_b.wr_collide), 64'h0);
    chk("x0_read", bus_b.rd_data, 64'h0);

    // Single port-0 write with a same-cycle read
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hABCD;
    set_rd(5'd9, 5'd0);
    #1;
    chk("bypass_b", bus_b.rd_data, {32'h0, 32'hABCD});
    chk("bypass_old_n", bus_n.rd_data, 64'h0);
    tick();
    idle();
    #1;
    chk("bypass_late_n", bus_n.rd_data, {32'h0, 32'hABCD});
    chk("bypass_stored_b", bus_b.rd_data, {32'h0, 32'hABCD});

    // Port priority on the bypass path, read through port 1
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h2;
    set_rd(5'd0, 5'd3);
    #1;
    chk("prio_bypass_b", bus_b.rd_data, {32'h2, 32'h0});
    chk("prio_old_n", bus_n.rd_data, 64'h0);
    tick();
    idle();
    #1;
    chk("prio_stored_n", bus_n.rd_data, {32'h2, 32'h0});
    chk("prio_collide_b", 64'(bus_b.wr_collide), 64'h1);

    // Distinct addresses commit together
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hA;
    we1 = 1'b1; wa1 = 5'd11; wd1 = 32'hB;
    set_rd(5'd10, 5'd11);
    #1;
    chk("dual_bypass_b", bus_b.rd_data, {32'hB, 32'hA});
    tick();
    idle();
    #1;
    chk("dual_stored_n", bus_n.rd_data, {32'hB, 32'hA});
    chk("dual_collide", 64'(bus_n.wr_collide), 64'h0);

    // Asynchronous reset in RUN, then a fresh sweep
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h55;
    tick();
    idle();
    set_rd(5'd4, 5'd2);
    #1;
    chk("pre_rst_x4", bus_n.rd_data, {32'd1020, 32'h55});
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ready_b", 64'(bus_b.ready), 64'h0);
    chk("async_rst_ready_n", 64'(bus_n.ready), 64'h0);
    chk("async_rst_rd", bus_b.rd_data, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_sweep();
    chk("resweep_x4_x2_b", bus_b.rd_data, {32'd1020, 32'h0});
    chk("resweep_x4_x2_n", bus_n.rd_data, {32'd1020, 32'h0});
    chk("resweep_no_x", 64'($isunknown(bus_n.rd_data)), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
